// File: rtl/smi_arb_pkg.sv
// ============================================================================
//  Module   : smi_arb_pkg
//  Purpose  : Shared definitions for the SMI stream arbiter: bus-ownership
//             state encoding and default watermark / quota / timing values.
//  Contents : arb_state_t  - 2-bit state code, also exported on o_state
//             c_DEF_*      - default parameter values for the arbiter
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package smi_arb_pkg;

    // The numeric codes are visible to software through o_state, so the
    // encoding is fixed rather than left to the tool.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RX_BURST   = 2'd1,
        ST_TX_BURST   = 2'd2,
        ST_TURNAROUND = 2'd3
    } arb_state_t;

    localparam int c_DEF_FILL_W    = 11;
    localparam int c_DEF_TX_LOW_WM = 500;
    localparam int c_DEF_TX_HIGH_WM = 984;
    localparam int c_DEF_RX_QUOTA  = 256;
    localparam int c_DEF_TX_QUOTA  = 256;
    localparam int c_DEF_TA_CYCLES = 4;
    localparam int c_DEF_TIMEOUT   = 4096;

    // Larger of two integers; used to size the shared word counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : smi_arb_pkg

`default_nettype wire

// File: rtl/smi_watermark_hyst.sv
// ============================================================================
//  Module   : smi_watermark_hyst
//  Purpose  : Registered hysteresis flag on a FIFO fill level. The flag sets
//             when the level drops below LOW, clears once it reaches HIGH and
//             holds in between. A disabled stream forces the flag low.
//  Ports    : i_clk    - clock
//             i_rst    - synchronous active-high reset (flag -> 0)
//             i_level  - fill level, W bits
//             i_enable - stream enable; 0 forces o_need low
//             o_need   - registered hysteresis flag
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module smi_watermark_hyst #(
    parameter int W    = 11,
    parameter int LOW  = 500,
    parameter int HIGH = 984
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_level,
    input  logic         i_enable,
    output logic         o_need
);

    localparam logic [W-1:0] c_LOW  = W'(LOW);
    localparam logic [W-1:0] c_HIGH = W'(HIGH);

    logic r_need;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_need <= 1'b0;
        end else if (!i_enable) begin
            r_need <= 1'b0;
        end else if (i_level < c_LOW) begin
            r_need <= 1'b1;
        end else if (i_level >= c_HIGH) begin
            r_need <= 1'b0;
        end
    end

    assign o_need = r_need;

endmodule : smi_watermark_hyst

`default_nettype wire

// File: rtl/smi_stream_arbiter.sv
// ============================================================================
//  Module   : smi_stream_arbiter
//  Purpose  : Time-shares the 8-bit SMI bus between the RX stream (FPGA to
//             host) and the TX stream (host to FPGA). Chooses the bus owner,
//             raises the host DMA request, and enforces burst quotas, a
//             word watchdog, TX watermark hysteresis and bus turnaround.
//  Ports    : i_sys_clk        - system clock
//             i_reset          - synchronous active-high reset
//             i_rx_enable      - RX streaming enabled
//             i_tx_enable      - TX streaming enabled
//             i_rx_fifo_empty  - framed RX FIFO empty
//             i_rx_word_pulled - one pulse per RX word pulled
//             i_tx_fill_level  - TX FIFO fill level
//             i_tx_word_pushed - one pulse per TX word pushed
//             i_smi_idle       - no SMI strobe active this cycle
//             o_smi_read_req   - host read request (RX burst)
//             o_smi_write_req  - host write request (TX burst)
//             o_drive_bus      - FPGA may drive the SMI data lines
//             o_state          - current state code
//             o_timeout        - one-cycle pulse on watchdog burst abort
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module smi_stream_arbiter
    import smi_arb_pkg::*;
#(
    parameter int FILL_W     = c_DEF_FILL_W,
    parameter int TX_LOW_WM  = c_DEF_TX_LOW_WM,
    parameter int TX_HIGH_WM = c_DEF_TX_HIGH_WM,
    parameter int RX_QUOTA   = c_DEF_RX_QUOTA,
    parameter int TX_QUOTA   = c_DEF_TX_QUOTA,
    parameter int TA_CYCLES  = c_DEF_TA_CYCLES,
    parameter int TIMEOUT    = c_DEF_TIMEOUT
) (
    input  logic              i_sys_clk,
    input  logic              i_reset,
    input  logic              i_rx_enable,
    input  logic              i_tx_enable,
    input  logic              i_rx_fifo_empty,
    input  logic              i_rx_word_pulled,
    input  logic [FILL_W-1:0] i_tx_fill_level,
    input  logic              i_tx_word_pushed,
    input  logic              i_smi_idle,
    output logic              o_smi_read_req,
    output logic              o_smi_write_req,
    output logic              o_drive_bus,
    output logic [1:0]        o_state,
    output logic              o_timeout
);

    // ------------------------------------------------------------------
    // Counter sizing
    // ------------------------------------------------------------------
    localparam int c_WC_W = $clog2(max_int(RX_QUOTA, TX_QUOTA) + 1);
    localparam int c_WD_W = $clog2(TIMEOUT + 1);
    localparam int c_TA_W = $clog2(TA_CYCLES + 1);

    localparam logic [c_WC_W-1:0] c_RX_Q    = c_WC_W'(RX_QUOTA);
    localparam logic [c_WC_W-1:0] c_TX_Q    = c_WC_W'(TX_QUOTA);
    localparam logic [c_WD_W-1:0] c_TO      = c_WD_W'(TIMEOUT);
    localparam logic [c_TA_W-1:0] c_TA      = c_TA_W'(TA_CYCLES);
    localparam logic [c_TA_W-1:0] c_TA_LAST = c_TA_W'(TA_CYCLES - 1);

    // ------------------------------------------------------------------
    // TX need flag (registered hysteresis)
    // ------------------------------------------------------------------
    logic w_tx_need;

    smi_watermark_hyst #(
        .W    (FILL_W),
        .LOW  (TX_LOW_WM),
        .HIGH (TX_HIGH_WM)
    ) u_tx_hyst (
        .i_clk    (i_sys_clk),
        .i_rst    (i_reset),
        .i_level  (i_tx_fill_level),
        .i_enable (i_tx_enable),
        .o_need   (w_tx_need)
    );

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    arb_state_t        r_state;
    logic              r_last_tx;
    logic [c_WC_W-1:0] r_word_cnt;
    logic [c_WD_W-1:0] r_wd_cnt;
    logic [c_TA_W-1:0] r_ta_cnt;
    logic              r_read_req;
    logic              r_write_req;
    logic              r_drive_bus;
    logic              r_timeout;

    arb_state_t w_state_nxt;
    logic       w_rx_ready;
    logic       w_in_burst;
    logic       w_word_pulse;
    logic       w_quota_hit;
    logic       w_wd_hit;
    logic       w_ta_done;
    logic       w_grant;

    always_comb begin
        w_rx_ready   = i_rx_enable & ~i_rx_fifo_empty;
        w_in_burst   = (r_state == ST_RX_BURST) || (r_state == ST_TX_BURST);
        // Only the pulse belonging to the active direction counts; pulses
        // outside a burst are ignored.
        w_word_pulse = ((r_state == ST_RX_BURST) & i_rx_word_pulled) |
                       ((r_state == ST_TX_BURST) & i_tx_word_pushed);
        w_quota_hit  = (r_state == ST_RX_BURST) ? (r_word_cnt == c_RX_Q)
                                                : (r_word_cnt == c_TX_Q);
        w_wd_hit     = (r_wd_cnt == c_TO);
        // Leave turnaround on the idle cycle that completes the required run.
        w_ta_done    = i_smi_idle && (r_ta_cnt == c_TA_LAST);

        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_ready && w_tx_need) begin
                    // Tie-break: serve the direction not served last.
                    w_state_nxt = r_last_tx ? ST_RX_BURST : ST_TX_BURST;
                end else if (w_rx_ready) begin
                    w_state_nxt = ST_RX_BURST;
                end else if (w_tx_need) begin
                    w_state_nxt = ST_TX_BURST;
                end
            end
            ST_RX_BURST: begin
                // The drain/disable exit waits for an idle bus so a strobe
                // in flight is never cut short.
                if (w_quota_hit || w_wd_hit ||
                    ((i_rx_fifo_empty || !i_rx_enable) && i_smi_idle)) begin
                    w_state_nxt = ST_TURNAROUND;
                end
            end
            ST_TX_BURST: begin
                if (w_quota_hit || w_wd_hit || (!w_tx_need && i_smi_idle)) begin
                    w_state_nxt = ST_TURNAROUND;
                end
            end
            ST_TURNAROUND: begin
                if (w_ta_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_grant = (r_state == ST_IDLE) && (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_last_tx   <= 1'b1;
            r_word_cnt  <= '0;
            r_wd_cnt    <= '0;
            r_ta_cnt    <= '0;
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_drive_bus <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Outputs are registered copies of the decode of the new state,
            // so they always agree with o_state in the same cycle.
            r_read_req  <= (w_state_nxt == ST_RX_BURST);
            r_write_req <= (w_state_nxt == ST_TX_BURST);
            r_drive_bus <= (w_state_nxt == ST_RX_BURST);
            r_timeout   <= w_in_burst && w_wd_hit;

            // Word counter: cleared on grant, saturates at the quota.
            if (w_grant) begin
                r_word_cnt <= '0;
            end else if (w_word_pulse && !w_quota_hit) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end

            // Watchdog: restarts on every word, saturates at TIMEOUT.
            if (w_grant || !w_in_burst || w_word_pulse) begin
                r_wd_cnt <= '0;
            end else if (!w_wd_hit) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end

            // Turnaround counter: consecutive idle cycles, reset by activity.
            if (r_state != ST_TURNAROUND || !i_smi_idle) begin
                r_ta_cnt <= '0;
            end else if (r_ta_cnt != c_TA) begin
                r_ta_cnt <= r_ta_cnt + 1'b1;
            end

            if (w_in_burst && (w_state_nxt == ST_TURNAROUND)) begin
                r_last_tx <= (r_state == ST_TX_BURST);
            end
        end
    end

    assign o_smi_read_req  = r_read_req;
    assign o_smi_write_req = r_write_req;
    assign o_drive_bus     = r_drive_bus;
    assign o_state         = r_state;
    assign o_timeout       = r_timeout;

endmodule : smi_stream_arbiter

`default_nettype wire

// File: tb/tb_smi_stream_arbiter.sv
// ============================================================================
//  Module   : tb_smi_stream_arbiter
//  Purpose  : Directed self-checking bench for smi_stream_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_smi_stream_arbiter;

    localparam int c_TA = 4;
    localparam int c_TO = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en, tx_en, rx_empty, rx_pulled, tx_pushed, smi_idle;
    logic [10:0] fill;
    logic        read_req, write_req, drive_bus, timeout;
    logic [1:0]  state;

    int n_vec  = 0;
    int n_err  = 0;
    int n_ovl  = 0;
    int n      = 0;

    always #5 clk = ~clk;

    smi_stream_arbiter dut (
        .i_sys_clk        (clk),
        .i_reset          (rst),
        .i_rx_enable      (rx_en),
        .i_tx_enable      (tx_en),
        .i_rx_fifo_empty  (rx_empty),
        .i_rx_word_pulled (rx_pulled),
        .i_tx_fill_level  (fill),
        .i_tx_word_pushed (tx_pushed),
        .i_smi_idle       (smi_idle),
        .o_smi_read_req   (read_req),
        .o_smi_write_req  (write_req),
        .o_drive_bus      (drive_bus),
        .o_state          (state),
        .o_timeout        (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (drive_bus && write_req) n_ovl++;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (state != 2'd0 && k < 50) begin
            tick();
            k++;
        end
        chk(tag, 32'(state), 32'd0);
    endtask

    // Wait for a grant, check its direction and gap, then run a full quota
    // of 256 words and check the quota exit timing.
    task automatic run_burst(input string tag, input logic [1:0] exp_dir, input bit chk_gap, input int gap0);
        int gap;
        gap = gap0;
        while (state != 2'd1 && state != 2'd2 && gap < 50) begin
            tick();
            gap++;
        end
        chk({tag, "_dir"}, 32'(state), 32'(exp_dir));
        if (chk_gap) chk({tag, "_gap_ok"}, 32'(gap >= c_TA + 1), 32'd1);
        if (exp_dir == 2'd1) rx_pulled = 1'b1; else tx_pushed = 1'b1;
        for (int i = 0; i < 256; i++) tick();
        rx_pulled = 1'b0;
        tx_pushed = 1'b0;
        chk({tag, "_held_at_quota"}, 32'(state), 32'(exp_dir));
        tick();
        chk({tag, "_quota_exit"}, 32'(state), 32'd3);
    endtask

    initial begin
        rst = 1'b1; rx_en = 1'b0; tx_en = 1'b1; rx_empty = 1'b1;
        rx_pulled = 1'b0; tx_pushed = 1'b0; smi_idle = 1'b1; fill = 11'd1000;
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'({read_req, write_req, drive_bus, timeout}), 32'd0);

        // --- RX grant and quota exit ---------------------------------------
        rst = 1'b0;
        tick();
        chk("idle_no_elig", 32'(state), 32'd0);
        rx_en = 1'b1; rx_empty = 1'b0; smi_idle = 1'b0;
        tick();
        chk("rx_grant_req", 32'({read_req, write_req, drive_bus}), 32'b101);
        chk("rx_grant_state", 32'(state), 32'd1);
        rx_pulled = 1'b1;
        for (int i = 0; i < 256; i++) tick();
        rx_pulled = 1'b0;
        chk("rx_256_still_req", 32'(read_req), 32'd1);
        tick();
        chk("rx_quota_drop", 32'({read_req, drive_bus}), 32'd0);
        chk("rx_quota_ta", 32'(state), 32'd3);
        rx_en = 1'b0; smi_idle = 1'b1;
        wait_idle("rx_ta_idle");

        // --- TX hysteresis -----------------------------------------------
        fill = 11'd990;
        tick(); tick();
        chk("tx_990_no_req", 32'(write_req), 32'd0);
        fill = 11'd499;
        tick();
        chk("tx_need_lag", 32'(write_req), 32'd0);
        tick();
        chk("tx_grant_req", 32'({read_req, write_req, drive_bus}), 32'b010);
        fill = 11'd600;
        tick(); tick(); tick();
        chk("tx_600_held", 32'(write_req), 32'd1);
        fill = 11'd984;
        tick();
        chk("tx_984_cur_cycle", 32'(write_req), 32'd1);
        tick();
        chk("tx_984_exit", 32'(state), 32'd3);
        chk("tx_984_req_low", 32'(write_req), 32'd0);
        wait_idle("tx_ta_idle");

        // --- Alternation with both eligible ---------------------------------
        rx_en = 1'b1; rx_empty = 1'b0; fill = 11'd100;
        run_burst("alt1_rx", 2'd1, 1'b0, 0);
        run_burst("alt2_tx", 2'd2, 1'b1, 1);
        run_burst("alt3_rx", 2'd1, 1'b1, 1);
        chk("no_drive_write_overlap", 32'(n_ovl), 32'd0);

        // --- Watchdog timeout ----------------------------------------------
        rx_en = 1'b0; fill = 11'd1000;
        wait_idle("pre_to_idle");
        rx_en = 1'b1; rx_empty = 1'b0; smi_idle = 1'b0;
        tick();
        chk("to_grant", 32'(state), 32'd1);
        n = 0;
        while (!timeout && n < 5000) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(n), 32'(c_TO + 1));
        chk("to_state_ta", 32'(state), 32'd3);
        tick();
        chk("to_single_pulse", 32'(timeout), 32'd0);
        rx_en = 1'b0; smi_idle = 1'b1;
        wait_idle("to_ta_idle");

        // --- Enable drop during active strobes ------------------------------
        rx_en = 1'b1; rx_empty = 1'b0; smi_idle = 1'b0;
        tick(); tick();
        rx_en = 1'b0;
        tick(); tick(); tick();
        chk("en_drop_held", 32'(read_req), 32'd1);
        smi_idle = 1'b1;
        tick();
        chk("en_drop_release", 32'(read_req), 32'd0);
        chk("en_drop_ta", 32'(state), 32'd3);
        wait_idle("en_ta_idle");

        // --- Reset mid TX burst, then RX wins first -------------------------
        fill = 11'd100;
        n = 0;
        while (state != 2'd2 && n < 20) begin
            tick();
            n++;
        end
        chk("pre_rst_tx", 32'(state), 32'd2);
        rst = 1'b1;
        tick();
        chk("mid_rst_outs", 32'({read_req, write_req, drive_bus, timeout}), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        rst = 1'b0; rx_en = 1'b0;
        tick();
        rx_en = 1'b1; rx_empty = 1'b0;
        tick();
        chk("post_rst_rx_first", 32'(state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_smi_stream_arbiter

`default_nettype wire
